// File: rtl/red_pitaya_adc_pkg.sv
// Shared constants and helpers for the Red Pitaya ADC receive path.
// Code conversion from the ADC's inverted-magnitude format and lane saturation.
package red_pitaya_adc_pkg;

    localparam int LANE_W  = 16;
    localparam int ADC_W   = 14;
    localparam int RATIO_W = 16;
    localparam int ACC_W   = ADC_W + RATIO_W;

    localparam logic signed [ACC_W-1:0] LANE_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] LANE_MIN = ACC_W'(-32768);

    function automatic logic signed [ADC_W-1:0] adc_to_signed(
        input logic [ADC_W-1:0] raw
    );
        return {raw[ADC_W-1], ~raw[ADC_W-2:0]};
    endfunction

    function automatic logic [LANE_W-1:0] sat16(
        input logic signed [ACC_W-1:0] sum,
        input logic [4:0]              sh
    );
        logic signed [ACC_W-1:0] s;
        s = sum >>> sh;
        if (s > LANE_MAX) return 16'h7FFF;
        if (s < LANE_MIN) return 16'h8000;
        return s[LANE_W-1:0];
    endfunction

endpackage

// File: rtl/axis_fifo2.sv
// Two-entry AXI4-Stream output buffer.
// Push is pre-qualified by the parent; simultaneous push and pop on full is legal.
module axis_fifo2 #(
    parameter int W = 32
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] m_axis_tdata,
    output logic         m_axis_tvalid
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign full          = (count == 2'd2);
    assign m_axis_tvalid = (count != 2'd0);
    assign m_axis_tdata  = mem[rd_ptr];

endmodule

// File: rtl/axis_red_pitaya_adc_decim.sv
// Red Pitaya ADC capture: pin registers, code conversion, boxcar decimator,
// shift-saturate and a 2-entry AXI4-Stream output buffer with drop status.
module axis_red_pitaya_adc_decim
    import red_pitaya_adc_pkg::*;
#(
    parameter int ADC_DATA_WIDTH   = 14,
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int RATIO_WIDTH      = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [ADC_DATA_WIDTH-1:0]   adc_dat_a,
    input  logic [ADC_DATA_WIDTH-1:0]   adc_dat_b,
    output logic                        adc_csn,
    input  logic                        cfg_enable,
    input  logic [RATIO_WIDTH-1:0]      cfg_ratio,
    input  logic [4:0]                  cfg_shift,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [15:0]                 sts_drops,
    output logic                        sts_overrun
);

    localparam int AW = ADC_DATA_WIDTH + RATIO_WIDTH;

    logic [ADC_DATA_WIDTH-1:0]        raw_a;
    logic [ADC_DATA_WIDTH-1:0]        raw_b;
    logic                             raw_vld;
    logic signed [ADC_DATA_WIDTH-1:0] conv_a;
    logic signed [ADC_DATA_WIDTH-1:0] conv_b;
    logic [RATIO_WIDTH-1:0]           cnt;
    logic [RATIO_WIDTH-1:0]           n_q;
    logic [RATIO_WIDTH-1:0]           n_cur;
    logic                             last;
    logic signed [AW-1:0]             acc_a;
    logic signed [AW-1:0]             acc_b;
    logic signed [AW-1:0]             sum_a;
    logic signed [AW-1:0]             sum_b;
    logic signed [AW-1:0]             res_a;
    logic signed [AW-1:0]             res_b;
    logic                             res_vld;
    logic                             s3_vld;
    logic [AXIS_TDATA_WIDTH-1:0]      s3_data;
    logic                             full;
    logic                             pop;
    logic                             push;
    logic                             drop;

    assign adc_csn = 1'b1;

    // raw_vld keeps the reset-cleared pin registers out of the first block
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            raw_a   <= '0;
            raw_b   <= '0;
            raw_vld <= 1'b0;
        end else begin
            raw_a   <= adc_dat_a;
            raw_b   <= adc_dat_b;
            raw_vld <= 1'b1;
        end
    end

    always_comb begin
        conv_a = adc_to_signed(raw_a);
        conv_b = adc_to_signed(raw_b);
        sum_a  = acc_a + AW'(conv_a);
        sum_b  = acc_b + AW'(conv_b);
        n_cur  = n_q;
        if (cnt == '0)
            n_cur = (cfg_ratio == '0) ? RATIO_WIDTH'(1) : cfg_ratio;
        last = (cnt == n_cur - RATIO_WIDTH'(1));
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt     <= '0;
            n_q     <= '0;
            acc_a   <= '0;
            acc_b   <= '0;
            res_a   <= '0;
            res_b   <= '0;
            res_vld <= 1'b0;
        end else begin
            res_vld <= 1'b0;
            if (raw_vld && cfg_enable) begin
                n_q <= n_cur;
                if (last) begin
                    res_a   <= sum_a;
                    res_b   <= sum_b;
                    res_vld <= 1'b1;
                    acc_a   <= '0;
                    acc_b   <= '0;
                    cnt     <= '0;
                end else begin
                    acc_a <= sum_a;
                    acc_b <= sum_b;
                    cnt   <= cnt + RATIO_WIDTH'(1);
                end
            end else begin
                acc_a <= '0;
                acc_b <= '0;
                cnt   <= '0;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s3_vld  <= 1'b0;
            s3_data <= '0;
        end else begin
            s3_vld <= res_vld;
            if (res_vld)
                s3_data <= {sat16(res_b, cfg_shift), sat16(res_a, cfg_shift)};
        end
    end

    assign pop  = m_axis_tvalid & m_axis_tready;
    assign push = s3_vld & (~full | pop);
    assign drop = s3_vld & full & ~pop;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sts_drops   <= '0;
            sts_overrun <= 1'b0;
        end else if (drop) begin
            sts_overrun <= 1'b1;
            if (sts_drops != 16'hFFFF)
                sts_drops <= sts_drops + 16'd1;
        end
    end

    axis_fifo2 #(
        .W (AXIS_TDATA_WIDTH)
    ) u_fifo (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .push          (push),
        .push_data     (s3_data),
        .full          (full),
        .pop           (pop),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid)
    );

endmodule
